// File: rtl/apb_status_regfile.sv
// APB register file: NCH read-only status channels, one R/W control word, fixed wait states.
// Optional APB_STATUS_STICKY_EN adds a W1C change-detect STICKY register at NCH+1 and an irq output.
//
// state    | meaning
// ST_IDLE  | no transfer; a setup phase (PSEL & !PENABLE) on the bus is the edge that starts one
// ST_WAIT  | access phase, wait counter running, PREADY low
// ST_READY | response presented (PREADY high), waiting for the completing edge
module apb_status_regfile #(
   parameter int DWIDTH      = 8,
   parameter int NCH         = 4,
   parameter int AWIDTH      = 4,
   parameter int WAIT_CYCLES = 0,
   parameter logic [DWIDTH-1:0] CTRL_RST = '0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [AWIDTH-1:0]       PADDR,
   input  logic [DWIDTH-1:0]       PWDATA,
   input  logic [NCH*DWIDTH-1:0]   regr_in,
   output logic [DWIDTH-1:0]       ctrl_out,
   output logic [DWIDTH-1:0]       PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
`ifdef APB_STATUS_STICKY_EN
   ,
   output logic                    irq
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

   localparam logic [AWIDTH-1:0] A_CTRL    = AWIDTH'(NCH);
   localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

   state_t                       state, state_nxt;
   logic [3:0]                   cnt;
   logic [NCH-1:0][DWIDTH-1:0]   ch_reg;
   logic                         setup, load, complete;
   logic [DWIDTH-1:0]            rd_data;
   logic                         rd_err, wr_ctrl;
   logic                         pend_ctrl;
   logic [DWIDTH-1:0]            pend_data;
`ifdef APB_STATUS_STICKY_EN
   localparam logic [AWIDTH-1:0] A_STICKY = AWIDTH'(NCH + 1);
   logic [NCH-1:0]               sticky, chg, clr;
   logic                         wr_sticky, pend_clr;
`endif

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      setup     = PSEL & ~PENABLE;
      state_nxt = state;
      load      = 1'b0;
      complete  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (setup) begin
               if (WAIT_CYCLES == 0) begin
                  load      = 1'b1;
                  state_nxt = ST_READY;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!PSEL) begin
               state_nxt = ST_IDLE;
            end else if (cnt == 4'd1) begin
               load      = 1'b1;
               state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            // Anything other than a proper completion drops the transfer without side effects.
            complete  = PSEL & PENABLE;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b1;
      wr_ctrl = 1'b0;
`ifdef APB_STATUS_STICKY_EN
      wr_sticky = 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
         if (PADDR == AWIDTH'(i) && !PWRITE) begin
            rd_data = ch_reg[i];
            rd_err  = 1'b0;
         end
      end
      if (PADDR == A_CTRL) begin
         rd_err = 1'b0;
         if (PWRITE) wr_ctrl = 1'b1;
         else        rd_data = ctrl_out;
      end
`ifdef APB_STATUS_STICKY_EN
      if (PADDR == A_STICKY) begin
         rd_err = 1'b0;
         if (PWRITE) wr_sticky = 1'b1;
         else        rd_data   = DWIDTH'(sticky);
      end
`endif
   end

`ifdef APB_STATUS_STICKY_EN
   always_comb begin
      clr = (complete && pend_clr) ? pend_data[NCH-1:0] : '0;
      for (int i = 0; i < NCH; i++) chg[i] = ch_reg[i] != regr_in[i*DWIDTH +: DWIDTH];
   end
`endif

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         cnt       <= '0;
         ch_reg    <= '0;
         PREADY    <= 1'b0;
         PRDATA    <= '0;
         PSLVERR   <= 1'b0;
         ctrl_out  <= CTRL_RST;
         pend_ctrl <= 1'b0;
         pend_data <= '0;
`ifdef APB_STATUS_STICKY_EN
         pend_clr  <= 1'b0;
         sticky    <= '0;
         irq       <= 1'b0;
`endif
      end else begin
         ch_reg <= regr_in;
         if (state == ST_IDLE && setup)      cnt <= WAIT_INIT;
         else if (state == ST_WAIT && PSEL)  cnt <= cnt - 4'd1;
         if (load) begin
            PREADY    <= 1'b1;
            PRDATA    <= rd_data;
            PSLVERR   <= rd_err;
            pend_ctrl <= wr_ctrl;
            pend_data <= PWDATA;
`ifdef APB_STATUS_STICKY_EN
            pend_clr  <= wr_sticky;
`endif
         end else if (state == ST_READY) begin
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
            pend_ctrl <= 1'b0;
`ifdef APB_STATUS_STICKY_EN
            pend_clr  <= 1'b0;
`endif
         end
         if (complete && pend_ctrl) ctrl_out <= pend_data;
`ifdef APB_STATUS_STICKY_EN
         // A change on the clearing edge wins over the W1C.
         sticky <= (sticky & ~clr) | chg;
         irq    <= |(sticky & ctrl_out[NCH-1:0]);
`endif
      end
   end

endmodule
